// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : IF stage plus IF/ID pipeline register for an RV32IM pipeline.
//               Owns the PC and issues reads to instruction memory. Presents
//               the fetched instruction and its PC to decode. Handles memory
//               wait states, hazard stalls and taken-branch/jump redirects
//               from EX, and squashes the wrong-path instruction.
// Ports       : clk            - clock, all state updates on posedge
//               reset          - synchronous active-high reset
//               stall          - hazard unit request to hold IF/ID and PC
//               branch_taken   - EX redirect request
//               branch_address - redirect target, bits [1:0] ignored
//               imem_address   - instruction memory read address
//               imem_read      - instruction memory read request
//               imem_readdata  - instruction memory read data
//               imem_busywait  - memory not ready; hold request/address
//               pc_out         - IF/ID: PC of instruction
//               instruction    - IF/ID: instruction word
//               instr_valid    - IF/ID: 1 = real instruction, 0 = bubble
//               fetch_busy     - IF is waiting on memory
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic [31:0] imem_readdata,
  input  logic        imem_busywait,
  output logic [31:0] pc_out,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // issuing reads at pc
    HOLD  = 2'd1,  // word captured during a stall, waiting to enter IF/ID
    DRAIN = 2'd2   // redirected while an access was in flight; finish it
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pending_pc;
  logic [31:0] hold_instr;
  logic [31:0] branch_target;
  logic        mem_done;

  assign branch_target = branch_address & 32'hFFFF_FFFC;

  // In DRAIN pc still holds the in-flight address, so the address bus is
  // simply pc in every state and never moves while an access is pending.
  assign imem_address = pc;
  assign imem_read    = ((state == FETCH) || (state == DRAIN)) && !reset;
  assign fetch_busy   = imem_read && imem_busywait;
  assign mem_done     = !imem_busywait;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_VECTOR;
      state       <= FETCH;
      pc_out      <= RESET_VECTOR;
      instruction <= NOP_INSTR;
      instr_valid <= 1'b0;
      hold_instr  <= NOP_INSTR;
      pending_pc  <= 32'h0000_0000;
    end else if (branch_taken) begin
      // Squash whatever is in IF/ID and any word parked in hold_instr.
      pc_out      <= branch_target;
      instruction <= NOP_INSTR;
      instr_valid <= 1'b0;
      hold_instr  <= NOP_INSTR;
      if ((state != HOLD) && imem_busywait) begin
        // An access is still outstanding: let it finish before redirecting.
        pending_pc <= branch_target;
        state      <= DRAIN;
      end else begin
        pc    <= branch_target;
        state <= FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (mem_done && !stall) begin
            pc_out      <= pc;
            instruction <= imem_readdata;
            instr_valid <= 1'b1;
            pc          <= pc + 32'd4;
          end else if (mem_done && stall) begin
            // Data arrives while decode is stalled: park it so the memory
            // is not re-read when the stall releases.
            hold_instr <= imem_readdata;
            state      <= HOLD;
          end else if (!stall) begin
            pc_out      <= pc;
            instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            pc_out      <= pc;
            instruction <= hold_instr;
            instr_valid <= 1'b1;
            pc          <= pc + 32'd4;
            state       <= FETCH;
          end
        end
        DRAIN: begin
          // Wrong-path data is discarded; IF/ID keeps the flush bubble.
          if (mem_done) begin
            pc    <= pending_pc;
            state <= FETCH;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Self-checking bench for instruction_fetch_unit. A directed
//               prelude walks the documented scenarios, then random
//               stall/wait/branch/reset traffic runs against a behavioural
//               model of the fetch pointer and IF/ID contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

  localparam logic [31:0] C_RV  = 32'h0000_0000;
  localparam logic [31:0] C_NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_address = 32'h0;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] imem_readdata = 32'h0;
  logic        imem_busywait = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        fetch_busy;

  instruction_fetch_unit #(
    .RESET_VECTOR(C_RV),
    .NOP_INSTR   (C_NOP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_address(branch_address),
    .imem_address  (imem_address),
    .imem_read     (imem_read),
    .imem_readdata (imem_readdata),
    .imem_busywait (imem_busywait),
    .pc_out        (pc_out),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .fetch_busy    (fetch_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
  endtask

  // Memory image: every word address gets a distinct, non-NOP pattern.
  function automatic logic [31:0] img(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC0DE_0001;
  endfunction

  // ---- Reference model -----------------------------------------------------
  // ptr      : address the fetch unit is presenting to memory
  // parked   : a word already read but not yet delivered (stall caught it)
  // draining : an abandoned access is still outstanding, resume at 'resume'
  logic        m_init = 1'b0;
  logic [31:0] m_ptr, m_word, m_resume;
  logic        m_parked, m_draining;
  logic [31:0] m_pc, m_ins;
  logic        m_v;

  task automatic step(input logic r, input logic st, input logic br,
                      input logic [31:0] ba, input logic bw);
    logic rd_exp;
    logic done;
    logic [31:0] tgt;
    @(negedge clk);
    reset          = r;
    stall          = st;
    branch_taken   = br;
    branch_address = ba;
    imem_busywait  = bw;
    imem_readdata  = img(imem_address);
    #1;
    rd_exp = !r && m_init && !m_parked;
    if (r || m_init) begin
      chk("imem_read", {31'd0, imem_read}, {31'd0, rd_exp});
      chk("fetch_busy", {31'd0, fetch_busy}, {31'd0, rd_exp && bw});
    end
    if (m_init && !r) chk("imem_address", imem_address, m_ptr);

    // Advance the model by one clock.
    tgt  = {ba[31:2], 2'b00};
    done = rd_exp && !bw;
    if (r) begin
      m_init = 1'b1; m_ptr = C_RV; m_parked = 1'b0; m_draining = 1'b0;
      m_pc = C_RV; m_ins = C_NOP; m_v = 1'b0;
    end else if (br) begin
      m_pc = tgt; m_ins = C_NOP; m_v = 1'b0; m_parked = 1'b0;
      if (rd_exp && bw) begin m_draining = 1'b1; m_resume = tgt; end
      else begin m_draining = 1'b0; m_ptr = tgt; end
    end else if (m_draining) begin
      if (!bw) begin m_draining = 1'b0; m_ptr = m_resume; end
    end else if (st) begin
      if (done) begin m_parked = 1'b1; m_word = img(m_ptr); end
    end else if (m_parked || done) begin
      m_pc = m_ptr; m_ins = m_parked ? m_word : img(m_ptr); m_v = 1'b1;
      m_ptr = m_ptr + 32'd4; m_parked = 1'b0;
    end else begin
      m_pc = m_ptr; m_ins = C_NOP; m_v = 1'b0;
    end

    @(posedge clk);
    #1;
    chk("pc_out", pc_out, m_pc);
    chk("instruction", instruction, m_ins);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_v});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    // Reset, then straight-line fetch 0,4,8,...
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("reset_pc_out", pc_out, C_RV);
    chk("reset_instr", instruction, C_NOP);
    run(2);
    // Three wait states on 0x8.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("wait_then_pc8", pc_out, 32'h8);
    run(1);
    // Stall for four cycles while fetching 0x10.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    run(3);
    // Redirect under stall to an unaligned target.
    step(1'b0, 1'b1, 1'b1, 32'h103, 1'b0);
    chk("flush_pc_out", pc_out, 32'h100);
    run(1);
    chk("target_instr", instruction, img(32'h100));
    run(2);
    // Redirect while the memory is busy: old access drains first.
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    run(3);
    // Wrap-around at the top of the address space.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    run(3);
    // Reset in the middle of a drain.
    step(1'b0, 1'b0, 1'b1, 32'h80, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    run(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r, st, br, bw;
      logic [31:0] ba;
      r  = ($urandom_range(0, 99) < 2);
      st = ($urandom_range(0, 99) < 25);
      bw = ($urandom_range(0, 99) < 30);
      br = ($urandom_range(0, 99) < 10);
      ba = $urandom;
      if ($urandom_range(0, 3) == 0) ba = 32'hFFFF_FFF0 | {28'd0, ba[3:0]};
      step(r, st, br, ba, bw);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
